// File: rtl/seq_pattern_checker.sv
// Sequence checker: each antecedent cycle registers a pending check of val against
// the expected slice for residue (cyc mod MOD); the check completes one cycle later.
module seq_pattern_checker #(
    parameter int WIDTH   = 1,
    parameter int MOD     = 2,
    parameter int MAX_CYC = 11,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       val,
    input  logic [MOD*WIDTH-1:0]   exp_tbl,
    output logic [31:0]            cyc,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [3:0]             fail_res,
    output logic [CNT_W-1:0]       fail_count,
    output logic [31:0]            first_fail_cyc
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] LAST_CYC = 32'(MAX_CYC - 1);
    localparam logic [31:0] END_CYC  = 32'(MAX_CYC);
    localparam logic [3:0]  RES_LAST = 4'(MOD - 1);

    state_t           state, state_n;
    logic             issue;
    logic [3:0]       res, pend_res;
    logic             pend;
    logic [WIDTH-1:0] exp_sel;
    logic             mismatch;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // RUN entered with cyc already at the limit (MAX_CYC=1) issues nothing and drains.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    issue   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cyc >= END_CYC) begin
                    state_n = DRAIN;
                end else if (en) begin
                    issue = 1'b1;
                    if (cyc == LAST_CYC) state_n = DRAIN;
                end
            end
            DRAIN:   state_n = DONE;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_comb begin
        exp_sel = '0;
        for (int k = 0; k < MOD; k++) begin
            if (pend_res == 4'(k)) exp_sel = exp_tbl[k*WIDTH +: WIDTH];
        end
    end

    assign mismatch = pend && (val != exp_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc            <= '0;
            res            <= '0;
            pend           <= 1'b0;
            pend_res       <= '0;
            fail           <= 1'b0;
            fail_res       <= '0;
            fail_count     <= '0;
            first_fail_cyc <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                cyc      <= cyc + 32'd1;
                res      <= (res == RES_LAST) ? 4'd0 : res + 4'd1;
                pend_res <= res;
            end
            fail <= mismatch;
            // fail_count saturates, so zero means no mismatch since reset
            if (mismatch) begin
                fail_res <= pend_res;
                if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                if (fail_count == '0) first_fail_cyc <= cyc - 32'd1;
            end
        end
    end

endmodule
